// File: rtl/execute_load_store_ctrl.sv
// execute_load_store_ctrl
// Load/store sequencer between the execute stage and the data-memory port.
// It captures one request, presents a word-aligned address with a big-endian
// byte-lane mask and lane-replicated store data, and runs the DATAIO
// request/busy/valid handshake. For loads it extracts and zero-extends the
// returned data, then pulses a writeback.
// Optional feature macro: LSU_ALIGN_CHECK_EN. When it is defined, misaligned
// halfword and word accesses raise a fault pulse and never reach memory.
module execute_load_store_ctrl (
   input  logic        iCLOCK,
   input  logic        iRESET,
   input  logic        iFLUSH,
   input  logic        iEXE_VALID,
   input  logic        iEXE_WRITE,
   input  logic [1:0]  iEXE_SIZE,
   input  logic [31:0] iEXE_ADDR,
   input  logic [31:0] iEXE_WDATA,
   input  logic [4:0]  iEXE_DEST,
   output logic        oEXE_BUSY,
   output logic        oDATAIO_REQ,
   input  logic        iDATAIO_BUSY,
   output logic        oDATAIO_RW,
   output logic [31:0] oDATAIO_ADDR,
   output logic [3:0]  oDATAIO_MASK,
   output logic [31:0] oDATAIO_DATA,
   input  logic        iDATAIO_VALID,
   input  logic [31:0] iDATAIO_DATA,
   output logic        oWB_VALID,
   output logic [4:0]  oWB_DEST,
   output logic [31:0] oWB_DATA,
   output logic        oWB_FAULT
);

`ifdef LSU_ALIGN_CHECK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FAULT} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
`endif

   state_t      state_q, state_d;
   logic        rw_q, rw_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  dest_q, dest_d;
   logic        discard_q, discard_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_dest_q, wb_dest_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [3:0]  req_mask;
   logic [31:0] req_wdata;
   logic [31:0] load_data;
   logic        in_req;

`ifdef LSU_ALIGN_CHECK_EN
   logic        wb_fault_q, wb_fault_d;
   logic        req_misaligned;

   // A halfword needs an even address; a word needs all low address bits clear.
   always_comb begin
      req_misaligned = 1'b0;
      if (iEXE_SIZE == 2'd1) begin
         req_misaligned = iEXE_ADDR[0];
      end else if (iEXE_SIZE[1]) begin
         req_misaligned = (iEXE_ADDR[1:0] != 2'b00);
      end
   end
`endif

   // Decode the incoming request into its byte-lane mask and replicated store data.
   always_comb begin
      req_mask  = 4'b1111;
      req_wdata = iEXE_WDATA;
      case (iEXE_SIZE)
         2'd0: begin
            req_mask  = 4'b0001 << iEXE_ADDR[1:0];
            req_wdata = {4{iEXE_WDATA[7:0]}};
         end
         2'd1: begin
            req_mask  = iEXE_ADDR[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{iEXE_WDATA[15:0]}};
         end
         default: begin
            req_mask  = 4'b1111;
            req_wdata = iEXE_WDATA;
         end
      endcase
   end

   // Pick the addressed lanes out of the returned word (bit0 of mask = data[31:24]).
   always_comb begin
      load_data = iDATAIO_DATA;
      case (mask_q)
         4'b0001: load_data = {24'h0, iDATAIO_DATA[31:24]};
         4'b0010: load_data = {24'h0, iDATAIO_DATA[23:16]};
         4'b0100: load_data = {24'h0, iDATAIO_DATA[15:8]};
         4'b1000: load_data = {24'h0, iDATAIO_DATA[7:0]};
         4'b0011: load_data = {16'h0, iDATAIO_DATA[31:16]};
         4'b1100: load_data = {16'h0, iDATAIO_DATA[15:0]};
         default: load_data = iDATAIO_DATA;
      endcase
   end

   // Next-state logic for the access sequencer and the writeback registers.
   always_comb begin
      state_d    = state_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      data_d     = data_q;
      dest_d     = dest_q;
      discard_d  = discard_q;
      wb_valid_d = 1'b0;
      wb_dest_d  = wb_dest_q;
      wb_data_d  = wb_data_q;
`ifdef LSU_ALIGN_CHECK_EN
      wb_fault_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (iEXE_VALID && !iFLUSH) begin
               rw_d      = iEXE_WRITE;
               addr_d    = {iEXE_ADDR[31:2], 2'b00};
               mask_d    = req_mask;
               data_d    = req_wdata;
               dest_d    = iEXE_DEST;
               discard_d = 1'b0;
               state_d   = ST_REQ;
`ifdef LSU_ALIGN_CHECK_EN
               if (req_misaligned) begin
                  state_d = ST_FAULT;
               end
`endif
            end
         end
         ST_REQ: begin
            if (!iDATAIO_BUSY) begin
               state_d   = ST_WAIT;
               discard_d = iFLUSH;
            end else if (iFLUSH) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            discard_d = discard_q | iFLUSH;
            if (iDATAIO_VALID) begin
               state_d = ST_IDLE;
               if (!rw_q && !discard_q && !iFLUSH) begin
                  wb_valid_d = 1'b1;
                  wb_dest_d  = dest_q;
                  wb_data_d  = load_data;
               end
            end
         end
`ifdef LSU_ALIGN_CHECK_EN
         ST_FAULT: begin
            state_d = ST_IDLE;
            if (!iFLUSH) begin
               wb_fault_d = 1'b1;
               wb_dest_d  = dest_q;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State and capture registers; reset abandons any access in flight.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q    <= ST_IDLE;
         rw_q       <= 1'b0;
         addr_q     <= 32'h0;
         mask_q     <= 4'h0;
         data_q     <= 32'h0;
         dest_q     <= 5'h0;
         discard_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_dest_q  <= 5'h0;
         wb_data_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         mask_q     <= mask_d;
         data_q     <= data_d;
         dest_q     <= dest_d;
         discard_q  <= discard_d;
         wb_valid_q <= wb_valid_d;
         wb_dest_q  <= wb_dest_d;
         wb_data_q  <= wb_data_d;
      end
   end

`ifdef LSU_ALIGN_CHECK_EN
   // Fault pulse register, kept apart so the default build carries no fault logic.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         wb_fault_q <= 1'b0;
      end else begin
         wb_fault_q <= wb_fault_d;
      end
   end
   assign oWB_FAULT = wb_fault_q;
`else
   assign oWB_FAULT = 1'b0;
`endif

   // Memory-side outputs only carry the captured request while it is being offered.
   assign in_req       = (state_q == ST_REQ);
   assign oEXE_BUSY    = (state_q != ST_IDLE);
   assign oDATAIO_REQ  = in_req;
   assign oDATAIO_RW   = in_req & rw_q;
   assign oDATAIO_ADDR = in_req ? addr_q : 32'h0;
   assign oDATAIO_MASK = in_req ? mask_q : 4'h0;
   assign oDATAIO_DATA = (in_req && rw_q) ? data_q : 32'h0;
   assign oWB_VALID    = wb_valid_q;
   assign oWB_DEST     = wb_dest_q;
   assign oWB_DATA     = wb_data_q;

endmodule

// File: tb/tb_execute_load_store_ctrl.sv
// tb_execute_load_store_ctrl
// Drives directed and randomized load/store transactions into
// execute_load_store_ctrl and compares every cycle against a transaction-level
// model of the expected handshake timing, lane mask, store data and writeback.
// Honours LSU_ALIGN_CHECK_EN in the same way as the design.
module tb_execute_load_store_ctrl;

   logic        iCLOCK = 1'b0;
   logic        iRESET;
   logic        iFLUSH;
   logic        iEXE_VALID;
   logic        iEXE_WRITE;
   logic [1:0]  iEXE_SIZE;
   logic [31:0] iEXE_ADDR;
   logic [31:0] iEXE_WDATA;
   logic [4:0]  iEXE_DEST;
   logic        oEXE_BUSY;
   logic        oDATAIO_REQ;
   logic        iDATAIO_BUSY;
   logic        oDATAIO_RW;
   logic [31:0] oDATAIO_ADDR;
   logic [3:0]  oDATAIO_MASK;
   logic [31:0] oDATAIO_DATA;
   logic        iDATAIO_VALID;
   logic [31:0] iDATAIO_DATA;
   logic        oWB_VALID;
   logic [4:0]  oWB_DEST;
   logic [31:0] oWB_DATA;
   logic        oWB_FAULT;

   execute_load_store_ctrl dut (
      .iCLOCK(iCLOCK), .iRESET(iRESET), .iFLUSH(iFLUSH),
      .iEXE_VALID(iEXE_VALID), .iEXE_WRITE(iEXE_WRITE), .iEXE_SIZE(iEXE_SIZE),
      .iEXE_ADDR(iEXE_ADDR), .iEXE_WDATA(iEXE_WDATA), .iEXE_DEST(iEXE_DEST),
      .oEXE_BUSY(oEXE_BUSY), .oDATAIO_REQ(oDATAIO_REQ), .iDATAIO_BUSY(iDATAIO_BUSY),
      .oDATAIO_RW(oDATAIO_RW), .oDATAIO_ADDR(oDATAIO_ADDR), .oDATAIO_MASK(oDATAIO_MASK),
      .oDATAIO_DATA(oDATAIO_DATA), .iDATAIO_VALID(iDATAIO_VALID), .iDATAIO_DATA(iDATAIO_DATA),
      .oWB_VALID(oWB_VALID), .oWB_DEST(oWB_DEST), .oWB_DATA(oWB_DATA), .oWB_FAULT(oWB_FAULT)
   );

   // Free-running core clock, 10 time units per cycle.
   always #5 iCLOCK = ~iCLOCK;

   int testsRun = 0;
   int testsFailed = 0;

   logic        checkEn;
   logic        expBusy, expReq, expRw, expWbValid, expWbFault;
   logic [31:0] expAddr, expData, expWbData;
   logic [3:0]  expMask;
   logic [4:0]  expWbDest;
   logic        pendValid, pendFault;
   logic [4:0]  pendDest;
   logic [31:0] pendData;
   logic        txW;
   logic [1:0]  txSize;
   logic [31:0] txAddr, txWdata, txRdata;
   logic [4:0]  txDest;
   logic        curRw;
   logic [31:0] curAddr, curData;
   logic [3:0]  curMask;
   logic        litEn, litRw;
   logic [31:0] litAddr, litData;
   logic [3:0]  litMask;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Lanes touched by an access, counted from byte address 0.
   function automatic logic [3:0] modelMask(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] m;
      int first;
      int n;
      m = 4'h0;
      if (sz == 2'd0) begin
         first = int'(a[1:0]);
         n = 1;
      end else if (sz == 2'd1) begin
         first = a[1] ? 2 : 0;
         n = 2;
      end else begin
         first = 0;
         n = 4;
      end
      for (int k = first; k < first + n; k++) m[k] = 1'b1;
      return m;
   endfunction

   // Each lane carries the operand byte that would land at that byte address.
   function automatic logic [31:0] modelStore(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      logic [7:0]  b;
      r = 32'h0;
      for (int k = 0; k < 4; k++) begin
         if (sz == 2'd0) b = wd[7:0];
         else if (sz == 2'd1) b = ((k % 2) == 0) ? wd[15:8] : wd[7:0];
         else b = wd[31-8*k -: 8];
         r[31-8*k -: 8] = b;
      end
      return r;
   endfunction

   // Concatenate the selected bytes in address order, most significant first.
   function automatic logic [31:0] modelLoad(input logic [3:0] m, input logic [31:0] rd);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) r = (r << 8) | {24'h0, rd[31-8*k -: 8]};
      end
      return r;
   endfunction

   function automatic logic modelMisaligned(input logic [1:0] sz, input logic [31:0] a);
      return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
   endfunction

   // Compare every DUT output against the model in the middle of each cycle.
   always @(negedge iCLOCK) begin
      if (checkEn) begin
         checkOutput("exe_busy", 32'(oEXE_BUSY), 32'(expBusy));
         checkOutput("dataio_req", 32'(oDATAIO_REQ), 32'(expReq));
         checkOutput("dataio_rw", 32'(oDATAIO_RW), 32'(expRw));
         checkOutput("dataio_addr", oDATAIO_ADDR, expAddr);
         checkOutput("dataio_mask", 32'(oDATAIO_MASK), 32'(expMask));
         checkOutput("dataio_data", oDATAIO_DATA, expData);
         checkOutput("wb_valid", 32'(oWB_VALID), 32'(expWbValid));
         checkOutput("wb_fault", 32'(oWB_FAULT), 32'(expWbFault));
         checkOutput("wb_dest", 32'(oWB_DEST), 32'(expWbDest));
         checkOutput("wb_data", oWB_DATA, expWbData);
      end
   end

   // One clock cycle: publish what the outputs must be now, then drive the inputs.
   task automatic drive(input logic v, input logic fl, input logic bz, input logic dv,
                        input logic eBusy, input logic eReq);
      @(posedge iCLOCK);
      #1;
      expBusy = eBusy;
      expReq  = eReq;
      expRw   = eReq ? curRw : 1'b0;
      expAddr = eReq ? curAddr : 32'h0;
      expMask = eReq ? curMask : 4'h0;
      expData = (eReq && curRw) ? curData : 32'h0;
      expWbValid = pendValid;
      expWbFault = pendFault;
      if (pendValid || pendFault) expWbDest = pendDest;
      if (pendValid) expWbData = pendData;
      pendValid = 1'b0;
      pendFault = 1'b0;
      iEXE_VALID = v;
      if (v) begin
         iEXE_WRITE = txW;
         iEXE_SIZE  = txSize;
         iEXE_ADDR  = txAddr;
         iEXE_WDATA = txWdata;
         iEXE_DEST  = txDest;
      end else begin
         iEXE_WRITE = 1'($urandom);
         iEXE_SIZE  = 2'($urandom);
         iEXE_ADDR  = $urandom;
         iEXE_WDATA = $urandom;
         iEXE_DEST  = 5'($urandom);
      end
      iFLUSH        = fl;
      iDATAIO_BUSY  = bz;
      iDATAIO_VALID = dv;
      iDATAIO_DATA  = dv ? txRdata : $urandom;
   endtask

   // One whole request. mode: 1 flush at accept, 2 flush in REQ while busy,
   // 3 flush on the handshake cycle, 4 flush in WAIT (or FAULT), other = none.
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] d, input logic [31:0] rd,
                                input int busyCycles, input int mode, input int validDelay,
                                input int flushAt);
      logic discard;
      logic fl;
      txW = w; txSize = sz; txAddr = a; txWdata = wd; txDest = d; txRdata = rd;
      drive(1'b1, mode == 1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (mode == 1) return;
      curRw   = w;
      curAddr = {a[31:2], 2'b00};
      curMask = modelMask(sz, a);
      curData = modelStore(sz, wd);
`ifdef LSU_ALIGN_CHECK_EN
      if (modelMisaligned(sz, a)) begin
         fl = (mode == 4);
         drive(1'($urandom), fl, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
         pendFault = !fl;
         pendDest  = d;
         return;
      end
`endif
      discard = 1'b0;
      for (int i = 0; i <= busyCycles; i++) begin
         fl = ((mode == 2) && (i == flushAt) && (i < busyCycles)) || ((mode == 3) && (i == busyCycles));
         drive(1'($urandom), fl, i < busyCycles, 1'($urandom), 1'b1, 1'b1);
         if (litEn && i == 0) begin
            @(negedge iCLOCK);
            checkOutput("lit_req", 32'(oDATAIO_REQ), 32'h1);
            checkOutput("lit_rw", 32'(oDATAIO_RW), 32'(litRw));
            checkOutput("lit_addr", oDATAIO_ADDR, litAddr);
            checkOutput("lit_mask", 32'(oDATAIO_MASK), 32'(litMask));
            checkOutput("lit_data", oDATAIO_DATA, litData);
         end
         if (fl && i < busyCycles) return;
         if (fl) discard = 1'b1;
      end
      for (int j = 0; j <= validDelay; j++) begin
         fl = (mode == 4) && (j == flushAt);
         drive(1'($urandom), fl, 1'($urandom), j == validDelay, 1'b1, 1'b0);
         if (fl) discard = 1'b1;
      end
      if (!w && !discard) begin
         pendValid = 1'b1;
         pendDest  = d;
         pendData  = modelLoad(modelMask(sz, a), rd);
      end
   endtask

   task automatic idleCycle();
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
   endtask

   task automatic setResetExpect();
      expBusy = 1'b0; expReq = 1'b0; expRw = 1'b0;
      expAddr = 32'h0; expMask = 4'h0; expData = 32'h0;
      expWbValid = 1'b0; expWbFault = 1'b0; expWbDest = 5'h0; expWbData = 32'h0;
      pendValid = 1'b0; pendFault = 1'b0; pendDest = 5'h0; pendData = 32'h0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(oEXE_BUSY), 32'h0);
      checkOutput({tag, "_req"}, 32'(oDATAIO_REQ), 32'h0);
      checkOutput({tag, "_rw"}, 32'(oDATAIO_RW), 32'h0);
      checkOutput({tag, "_addr"}, oDATAIO_ADDR, 32'h0);
      checkOutput({tag, "_mask"}, 32'(oDATAIO_MASK), 32'h0);
      checkOutput({tag, "_data"}, oDATAIO_DATA, 32'h0);
      checkOutput({tag, "_wbv"}, 32'(oWB_VALID), 32'h0);
      checkOutput({tag, "_wbf"}, 32'(oWB_FAULT), 32'h0);
      checkOutput({tag, "_wbd"}, 32'(oWB_DEST), 32'h0);
      checkOutput({tag, "_wbdata"}, oWB_DATA, 32'h0);
   endtask

   initial begin
      checkEn = 1'b0;
      litEn = 1'b0; litRw = 1'b0; litAddr = 32'h0; litData = 32'h0; litMask = 4'h0;
      txW = 1'b0; txSize = 2'd0; txAddr = 32'h0; txWdata = 32'h0; txDest = 5'h0; txRdata = 32'h0;
      curRw = 1'b0; curAddr = 32'h0; curData = 32'h0; curMask = 4'h0;
      setResetExpect();
      iRESET = 1'b1; iFLUSH = 1'b0; iEXE_VALID = 1'b0; iEXE_WRITE = 1'b0; iEXE_SIZE = 2'd0;
      iEXE_ADDR = 32'h0; iEXE_WDATA = 32'h0; iEXE_DEST = 5'h0;
      iDATAIO_BUSY = 1'b0; iDATAIO_VALID = 1'b0; iDATAIO_DATA = 32'h0;
      repeat (2) @(posedge iCLOCK);
      #1;
      checkAllZero("reset");
      iRESET = 1'b0;
      checkEn = 1'b1;
      idleCycle();

      // Load word at 0x100, zero wait; writeback three cycles after accept.
      litEn = 1'b1; litRw = 1'b0; litAddr = 32'h100; litMask = 4'b1111; litData = 32'h0;
      applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 5'd7, 32'hAABBCCDD, 0, 0, 0, 0);
      litEn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("lw_wb_valid", 32'(oWB_VALID), 32'h1);
      checkOutput("lw_wb_data", oWB_DATA, 32'hAABBCCDD);
      checkOutput("lw_wb_dest", 32'(oWB_DEST), 32'd7);
      checkOutput("lw_busy", 32'(oEXE_BUSY), 32'h0);

      // Byte load at 0x103 and halfword load at 0x102.
      litEn = 1'b1; litAddr = 32'h100; litMask = 4'b1000;
      applyStimulus(1'b0, 2'd0, 32'h103, 32'h0, 5'd1, 32'h11223344, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("lb_wb_data", oWB_DATA, 32'h00000044);
      litMask = 4'b1100;
      applyStimulus(1'b0, 2'd1, 32'h102, 32'h0, 5'd2, 32'h11223344, 0, 0, 1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("lh_wb_data", oWB_DATA, 32'h00003344);

      // Byte store 0x5A at 0x201 with memory busy for four cycles.
      litRw = 1'b1; litAddr = 32'h200; litMask = 4'b0010; litData = 32'h5A5A5A5A;
      applyStimulus(1'b1, 2'd0, 32'h201, 32'h0000005A, 5'd3, 32'h0, 4, 0, 0, 0);
      litEn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("sb_no_wb", 32'(oWB_VALID), 32'h0);

      // Load flushed in WAIT, data returns three cycles later.
      applyStimulus(1'b0, 2'd2, 32'h300, 32'h0, 5'd4, 32'h12345678, 0, 4, 3, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("flush_no_wb", 32'(oWB_VALID), 32'h0);
      checkOutput("flush_busy", 32'(oEXE_BUSY), 32'h0);

      // Misaligned word load at 0x102.
`ifdef LSU_ALIGN_CHECK_EN
      applyStimulus(1'b0, 2'd2, 32'h102, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("mis_fault", 32'(oWB_FAULT), 32'h1);
      checkOutput("mis_dest", 32'(oWB_DEST), 32'd9);
      checkOutput("mis_no_wb", 32'(oWB_VALID), 32'h0);
`else
      litEn = 1'b1; litRw = 1'b0; litAddr = 32'h100; litMask = 4'b1111; litData = 32'h0;
      applyStimulus(1'b0, 2'd2, 32'h102, 32'h0, 5'd9, 32'hCAFEF00D, 0, 0, 0, 0);
      litEn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("mis_wb_data", oWB_DATA, 32'hCAFEF00D);
      checkOutput("mis_fault", 32'(oWB_FAULT), 32'h0);
`endif

      // Asynchronous reset while a request is being held off by memory.
      txW = 1'b0; txSize = 2'd2; txAddr = 32'h400; txWdata = 32'h0; txDest = 5'd5; txRdata = 32'h55AA55AA;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      curRw = 1'b0; curAddr = 32'h400; curMask = 4'b1111; curData = 32'h0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      checkEn = 1'b0;
      iRESET = 1'b1;
      #1;
      checkAllZero("async_rst");
      @(posedge iCLOCK);
      #1;
      iRESET = 1'b0;
      setResetExpect();
      iDATAIO_VALID = 1'b1;
      iDATAIO_BUSY = 1'b0;
      iEXE_VALID = 1'b0;
      checkEn = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge iCLOCK);
      checkOutput("stray_no_wb", 32'(oWB_VALID), 32'h0);
      idleCycle();

      // Randomized transactions with random gaps, stalls, latencies and flushes.
      for (int t = 0; t < 400; t++) begin
         int bc;
         int md;
         int vd;
         int fa;
         bc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         md = int'($urandom_range(0, 8));
         vd = int'($urandom_range(0, 3));
         if (md == 2) fa = (bc > 0) ? int'($urandom_range(0, bc - 1)) : 0;
         else fa = int'($urandom_range(0, vd));
         applyStimulus(1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
                       bc, md, vd, fa);
         repeat ($urandom_range(0, 2)) idleCycle();
      end
      repeat (3) idleCycle();
      @(negedge iCLOCK);
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
